// File: rtl/clock_monitor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : clock_monitor_pkg                                          |
// | Purpose : Shared types, default sizes and width helpers for the      |
// |           clock monitor slice.                                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package clock_monitor_pkg;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Default sizing of a production instance
  localparam int GATE_CYCLES_DEF    = 100000;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  // Counter widths for the default sizing
  localparam int GATE_W = $clog2(GATE_CYCLES_DEF);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES_DEF + 1);

  // Gate counter only has to reach GATE_CYCLES-1; keep at least one bit
  function automatic int gate_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  // Idle counter must be able to hold TIMEOUT_CYCLES itself
  function automatic int timeout_width(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : clock_monitor_if                                           |
// | Purpose : Control, monitored-clock and result signals of the clock   |
// |           monitor. master = firmware/driver side, slave = monitor.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface clock_monitor_if #(
  parameter int CNT_W = 24
);
  logic             enable;
  logic             mon_in;
  logic [CNT_W-1:0] edge_count;
  logic             count_valid;
  logic             count_ovf;
  logic             clk_present;
  logic             busy;

  modport master (
    output enable,
    output mon_in,
    input  edge_count,
    input  count_valid,
    input  count_ovf,
    input  clk_present,
    input  busy
  );

  modport slave (
    input  enable,
    input  mon_in,
    output edge_count,
    output count_valid,
    output count_ovf,
    output clk_present,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/sync_rise_det.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sync_rise_det                                              |
// | Purpose : Multi-flop synchroniser for an asynchronous level followed |
// |           by a history flop; emits a one-cycle rise pulse and the    |
// |           synchronised level. SYNC_STAGES must be at least 2.        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sync_rise_det #(
  parameter int SYNC_STAGES = 2
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  i_async,
  output logic o_rise,
  output logic o_level
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // Shift the async level through the synchroniser and keep one cycle of history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/clock_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : clock_monitor                                              |
// | Purpose : Counts rising edges of an asynchronous monitored clock     |
// |           over back-to-back gate windows and flags its presence.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int GATE_CYCLES    = GATE_CYCLES_DEF,
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int SYNC_STAGES    = 2
) (
  input  wire              clk,
  input  wire              rst_n,
  clock_monitor_if.slave   mon_bus
);

  localparam int                   c_gate_w    = gate_width(GATE_CYCLES);
  localparam int                   c_to_w      = timeout_width(TIMEOUT_CYCLES);
  localparam logic [c_gate_w-1:0]  c_gate_last = c_gate_w'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     c_cnt_max   = '1;
  localparam logic [c_to_w-1:0]    c_timeout   = c_to_w'(TIMEOUT_CYCLES);

  // Sequencer and window counters
  state_t              r_state;
  logic [c_gate_w-1:0] r_gate_cnt;
  logic [CNT_W-1:0]    r_edge_cnt;
  logic                r_sat;

  // Registered outputs
  logic [CNT_W-1:0]    r_edge_count;
  logic                r_count_valid;
  logic                r_count_ovf;
  logic                r_busy;

  // Presence tracking
  logic [c_to_w-1:0]   r_idle_cnt;
  logic                r_clk_present;

  // Edge detector outputs and next-value terms of the edge counter
  logic                w_rise_raw;
  logic                w_mon_level;
  logic                w_rise;
  logic [CNT_W-1:0]    w_edge_next;
  logic                w_sat_next;

  sync_rise_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_rise_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (mon_bus.mon_in),
    .o_rise  (w_rise_raw),
    .o_level (w_mon_level)
  );

  // A genuine rise always coincides with a high synced level
  assign w_rise = w_rise_raw & w_mon_level;

  // Saturating edge counter; a rise arriving at full scale marks the window overflowed
  always_comb begin
    w_edge_next = r_edge_cnt;
    w_sat_next  = r_sat;
    if (w_rise) begin
      if (r_edge_cnt == c_cnt_max) begin
        w_sat_next = 1'b1;
      end else begin
        w_edge_next = r_edge_cnt + 1'b1;
      end
    end
  end

  // Window sequencer: the result registers load on the final COUNT cycle so that
  // count_valid and the new edge_count are visible together while in LATCH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_gate_cnt    <= '0;
      r_edge_cnt    <= '0;
      r_sat         <= 1'b0;
      r_edge_count  <= '0;
      r_count_valid <= 1'b0;
      r_count_ovf   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_count_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mon_bus.enable) begin
            r_state <= ARM;
          end
        end
        ARM: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
          if (mon_bus.enable) begin
            r_state <= COUNT;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        COUNT: begin
          if (!mon_bus.enable) begin
            // Abort: the partial count is discarded and results are untouched
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gate_cnt <= r_gate_cnt + 1'b1;
            r_edge_cnt <= w_edge_next;
            r_sat      <= w_sat_next;
            if (r_gate_cnt == c_gate_last) begin
              r_state       <= LATCH;
              r_busy        <= 1'b0;
              r_edge_count  <= w_edge_next;
              r_count_ovf   <= w_sat_next;
              r_count_valid <= 1'b1;
            end
          end
        end
        LATCH: begin
          r_state <= mon_bus.enable ? ARM : IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Presence watchdog: runs regardless of the sequencer; a rise beats a timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle_cnt    <= '0;
      r_clk_present <= 1'b0;
    end else if (w_rise) begin
      r_idle_cnt    <= '0;
      r_clk_present <= 1'b1;
    end else if (r_idle_cnt != c_timeout) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
      if (r_idle_cnt == c_timeout - 1'b1) begin
        r_clk_present <= 1'b0;
      end
    end
  end

  assign mon_bus.edge_count  = r_edge_count;
  assign mon_bus.count_valid = r_count_valid;
  assign mon_bus.count_ovf   = r_count_ovf;
  assign mon_bus.clk_present = r_clk_present;
  assign mon_bus.busy        = r_busy;

endmodule
`default_nettype wire
